// File: rtl/hc_csr_bank.sv
// MMIO CSR bank for HardCloud AFUs: feature header, AFU ID, DSM base, buffer
// descriptors, start/soft-reset controls, sticky status and a busy-cycle counter.
module hc_csr_bank #(
  parameter int           NUM_BUFFERS = 4,
  parameter int           ADDR_W      = 42,
  parameter int           SIZE_W      = 32,
  parameter logic [127:0] AFU_ID      = 128'h0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          mmio_wr_valid,
  input  logic                          mmio_rd_valid,
  input  logic [15:0]                   mmio_addr,
  input  logic [8:0]                    mmio_tid,
  input  logic [63:0]                   mmio_wr_data,
  output logic                          mmio_rd_rsp_valid,
  output logic [8:0]                    mmio_rd_rsp_tid,
  output logic [63:0]                   mmio_rd_rsp_data,
  input  logic                          afu_busy,
  input  logic                          afu_done,
  output logic                          hc_start,
  output logic                          hc_soft_reset,
  output logic [29:0]                   hc_mode,
  output logic [ADDR_W-1:0]             hc_dsm_base,
  output logic [NUM_BUFFERS*ADDR_W-1:0] hc_buf_addr,
  output logic [NUM_BUFFERS*SIZE_W-1:0] hc_buf_size
);

  localparam logic [63:0] DFH = 64'h1000_0000_0400_0000;

  function automatic logic [63:0] addr_ext(input logic [ADDR_W-1:0] a);
    return 64'({a, 6'b0});
  endfunction

  function automatic logic [63:0] size_ext(input logic [SIZE_W-1:0] s);
    return 64'(s);
  endfunction

  logic              wr_vld_p0, rd_vld_p0, afu_busy_p0, afu_done_p0;
  logic [15:0]       addr_p0;
  logic [8:0]        tid_p0;
  logic [63:0]       wdata_p0;

  logic [ADDR_W-1:0] dsm_base;
  logic [ADDR_W-1:0] buf_addr [NUM_BUFFERS];
  logic [SIZE_W-1:0] buf_size [NUM_BUFFERS];
  logic [29:0]       mode;
  logic              done, start_err, start, soft_reset;
  logic [63:0]       busy_cycles;

  logic [14:0]       qaddr;
  logic [3:0]        buf_idx;
  logic              in_window, buf_hit, buf_sel;
  logic              wr_dsm, wr_ctrl, wr_status;
  logic              start_ok, start_bad, srst_req;
  logic [63:0]       rd_mux;
  logic              unused_bits;

  // Stage p0: bus request and AFU status inputs registered together so that
  // everything presented in one cycle is acted on at the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_vld_p0   <= 1'b0;
      rd_vld_p0   <= 1'b0;
      addr_p0     <= '0;
      tid_p0      <= '0;
      wdata_p0    <= '0;
      afu_busy_p0 <= 1'b0;
      afu_done_p0 <= 1'b0;
    end else begin
      wr_vld_p0   <= mmio_wr_valid;
      rd_vld_p0   <= mmio_rd_valid;
      addr_p0     <= mmio_addr;
      tid_p0      <= mmio_tid;
      wdata_p0    <= mmio_wr_data;
      afu_busy_p0 <= afu_busy;
      afu_done_p0 <= afu_done;
    end
  end

  // Decode works on 64-bit register indices; the odd DWORD bit is dropped.
  assign qaddr     = addr_p0[15:1];
  assign in_window = (addr_p0[15:8] == 8'h00);
  assign buf_hit   = (qaddr[14:5] == 10'h002);
  assign buf_idx   = qaddr[4:1];
  assign buf_sel   = qaddr[0];
  assign wr_dsm    = wr_vld_p0 && (qaddr == 15'h020);
  assign wr_ctrl   = wr_vld_p0 && (qaddr == 15'h021);
  assign wr_status = wr_vld_p0 && (qaddr == 15'h022);
  assign start_ok  = wr_ctrl && wdata_p0[0] && !afu_busy_p0;
  assign start_bad = wr_ctrl && wdata_p0[0] && afu_busy_p0;
  assign srst_req  = wr_ctrl && wdata_p0[1];
  assign unused_bits = addr_p0[0] ^ (^wdata_p0);

  always_comb begin
    rd_mux = '0;
    case (qaddr)
      15'h000: rd_mux = DFH;
      15'h001: rd_mux = AFU_ID[63:0];
      15'h002: rd_mux = AFU_ID[127:64];
      15'h020: rd_mux = addr_ext(dsm_base);
      15'h021: rd_mux = {32'b0, mode, 2'b0};
      15'h022: rd_mux = {61'b0, start_err, done, afu_busy_p0};
      15'h023: rd_mux = busy_cycles;
      default: begin
        if (buf_hit) begin
          for (int i = 0; i < NUM_BUFFERS; i++) begin
            if (buf_idx == i[3:0])
              rd_mux = buf_sel ? size_ext(buf_size[i]) : addr_ext(buf_addr[i]);
          end
        end
      end
    endcase
  end

  // Stage p1: register updates; reads above see the pre-write contents.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dsm_base    <= '0;
      mode        <= '0;
      start       <= 1'b0;
      soft_reset  <= 1'b0;
      done        <= 1'b0;
      start_err   <= 1'b0;
      busy_cycles <= '0;
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        buf_addr[i] <= '0;
        buf_size[i] <= '0;
      end
    end else begin
      start      <= start_ok;
      soft_reset <= srst_req;
      if (wr_dsm)  dsm_base <= wdata_p0[ADDR_W+5:6];
      if (wr_ctrl) mode     <= wdata_p0[31:2];
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        if (wr_vld_p0 && buf_hit && buf_idx == i[3:0]) begin
          if (buf_sel) buf_size[i] <= wdata_p0[SIZE_W-1:0];
          else         buf_addr[i] <= wdata_p0[ADDR_W+5:6];
        end
      end
      // Sticky bits: a set in the same cycle beats every clear source.
      if (afu_done_p0)
        done <= 1'b1;
      else if (start_ok || srst_req || (wr_status && wdata_p0[1]))
        done <= 1'b0;
      if (start_bad)
        start_err <= 1'b1;
      else if (srst_req || (wr_status && wdata_p0[2]))
        start_err <= 1'b0;
      if (start_ok || srst_req)
        busy_cycles <= '0;
      else if (afu_busy_p0 && busy_cycles != '1)
        busy_cycles <= busy_cycles + 64'd1;
    end
  end

  // Stage p1: read response.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mmio_rd_rsp_valid <= 1'b0;
      mmio_rd_rsp_tid   <= '0;
      mmio_rd_rsp_data  <= '0;
    end else begin
      mmio_rd_rsp_valid <= rd_vld_p0 && in_window;
      if (rd_vld_p0 && in_window) begin
        mmio_rd_rsp_tid  <= tid_p0;
        mmio_rd_rsp_data <= rd_mux;
      end
    end
  end

  assign hc_start      = start;
  assign hc_soft_reset = soft_reset;
  assign hc_mode       = mode;
  assign hc_dsm_base   = dsm_base;

  for (genvar g = 0; g < NUM_BUFFERS; g++) begin : g_buf
    assign hc_buf_addr[g*ADDR_W +: ADDR_W] = buf_addr[g];
    assign hc_buf_size[g*SIZE_W +: SIZE_W] = buf_size[g];
  end

endmodule

// File: tb/tb_hc_csr_bank.sv
// Bench for hc_csr_bank: read responses are checked against a scoreboard of
// expected tid/data/arrival cycle; control outputs are checked inline per test.
module tb_hc_csr_bank;
  localparam int NB = 4;
  localparam int AW = 42;
  localparam int SW = 32;
  localparam logic [127:0] ID = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              mmio_wr_valid = 1'b0, mmio_rd_valid = 1'b0;
  logic [15:0]       mmio_addr = '0;
  logic [8:0]        mmio_tid = '0;
  logic [63:0]       mmio_wr_data = '0;
  logic              mmio_rd_rsp_valid;
  logic [8:0]        mmio_rd_rsp_tid;
  logic [63:0]       mmio_rd_rsp_data;
  logic              afu_busy = 1'b0, afu_done = 1'b0;
  logic              hc_start, hc_soft_reset;
  logic [29:0]       hc_mode;
  logic [AW-1:0]     hc_dsm_base;
  logic [NB*AW-1:0]  hc_buf_addr;
  logic [NB*SW-1:0]  hc_buf_size;

  hc_csr_bank #(.NUM_BUFFERS(NB), .ADDR_W(AW), .SIZE_W(SW), .AFU_ID(ID)) dut (
    .clk(clk), .reset_n(reset_n),
    .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_rsp_valid(mmio_rd_rsp_valid), .mmio_rd_rsp_tid(mmio_rd_rsp_tid),
    .mmio_rd_rsp_data(mmio_rd_rsp_data),
    .afu_busy(afu_busy), .afu_done(afu_done),
    .hc_start(hc_start), .hc_soft_reset(hc_soft_reset), .hc_mode(hc_mode),
    .hc_dsm_base(hc_dsm_base), .hc_buf_addr(hc_buf_addr), .hc_buf_size(hc_buf_size)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [8:0] tid; logic [63:0] data; int at; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int passed = 0;
  int total  = 0;

  // Response monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (mmio_rd_rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL rsp_unexpected: got tid=%0h data=%h, required no response",
                 mmio_rd_rsp_tid, mmio_rd_rsp_data);
      end else begin
        mon_e = sb.pop_front();
        total++;
        if ({mmio_rd_rsp_tid, mmio_rd_rsp_data} !== {mon_e.tid, mon_e.data})
          $display("FAIL rsp_data tid %0h: got tid=%0h data=%h, required tid=%0h data=%h",
                   mon_e.tid, mmio_rd_rsp_tid, mmio_rd_rsp_data, mon_e.tid, mon_e.data);
        else passed++;
        total++;
        if (cyc !== mon_e.at)
          $display("FAIL rsp_latency tid %0h: got cycle %0d, required %0d", mon_e.tid, cyc, mon_e.at);
        else passed++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle();
    @(negedge clk);
    mmio_wr_valid = 1'b0;
    mmio_rd_valid = 1'b0;
    afu_done      = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] off, input logic [8:0] tid,
                         input logic [63:0] exp, input bit want);
    @(negedge clk);
    mmio_wr_valid = 1'b0;
    mmio_rd_valid = 1'b1;
    mmio_addr     = off >> 2;
    mmio_tid      = tid;
    if (want) sb.push_back('{tid, exp, cyc + 2});
  endtask

  task automatic do_write(input logic [15:0] off, input logic [63:0] data);
    @(negedge clk);
    mmio_rd_valid = 1'b0;
    mmio_wr_valid = 1'b1;
    mmio_addr     = off >> 2;
    mmio_wr_data  = data;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (mmio_rd_rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b required 0", mmio_rd_rsp_valid); else passed++;
    total++; if ({mmio_rd_rsp_tid, mmio_rd_rsp_data} !== 73'b0) $display("FAIL reset_rsp_fields: got %h required 0", {mmio_rd_rsp_tid, mmio_rd_rsp_data}); else passed++;
    total++; if ({hc_start, hc_soft_reset, hc_mode} !== 32'b0) $display("FAIL reset_ctrl: got %h required 0", {hc_start, hc_soft_reset, hc_mode}); else passed++;
    total++; if ({hc_dsm_base, hc_buf_addr, hc_buf_size} !== '0) $display("FAIL reset_addr_regs: got nonzero, required 0"); else passed++;
    reset_n = 1'b1;
    do_read(16'h110, 9'h11, 64'h0, 1'b1);
    do_read(16'h118, 9'h12, 64'h0, 1'b1);
    idle();
    wait_drain();
    total++; if (sb.size() !== 0) begin $display("FAIL drain_reset: got %0d pending, required 0", sb.size()); sb.delete(); end else passed++;
  endtask

  task automatic test_id_regs();
    do_read(16'h000, 9'd1, 64'h1000_0000_0400_0000, 1'b1);
    do_read(16'h008, 9'd2, ID[63:0], 1'b1);
    do_read(16'h010, 9'd3, ID[127:64], 1'b1);
    do_read(16'h018, 9'd4, 64'h0, 1'b1);
    do_read(16'h020, 9'd5, 64'h0, 1'b1);
    do_read(16'h014, 9'd6, ID[127:64], 1'b1);
    idle();
    wait_drain();
    total++; if (sb.size() !== 0) begin $display("FAIL drain_id: got %0d pending, required 0", sb.size()); sb.delete(); end else passed++;
  endtask

  task automatic test_buffers();
    logic [NB*AW-1:0] exp_ba;
    logic [NB*SW-1:0] exp_bs;
    exp_ba = '0; exp_ba[2*AW +: AW] = 42'h48_D159_E26B;
    exp_bs = '0; exp_bs[1*SW +: SW] = 32'h1234_5678;
    do_write(16'h220, 64'h0000_1234_5678_9AC0);
    do_write(16'h218, 64'hDEAD_BEEF_1234_5678);
    do_write(16'h248, 64'hFFFF_FFFF);
    do_write(16'h240, 64'hFFFF_FFFF_FFFF_FFFF);
    do_write(16'h100, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(); idle();
    total++; if (hc_buf_addr !== exp_ba) $display("FAIL buf_addr_out: got %h required %h", hc_buf_addr, exp_ba); else passed++;
    total++; if (hc_buf_size !== exp_bs) $display("FAIL buf_size_out: got %h required %h", hc_buf_size, exp_bs); else passed++;
    total++; if (hc_dsm_base !== {AW{1'b1}}) $display("FAIL dsm_out: got %h required all ones", hc_dsm_base); else passed++;
    do_read(16'h220, 9'h20, 64'h0000_1234_5678_9AC0, 1'b1);
    do_read(16'h218, 9'h21, 64'h0000_0000_1234_5678, 1'b1);
    do_read(16'h248, 9'h22, 64'h0, 1'b1);
    do_read(16'h240, 9'h23, 64'h0, 1'b1);
    do_read(16'h100, 9'h24, 64'h0000_FFFF_FFFF_FFC0, 1'b1);
    do_read(16'h028, 9'h25, 64'h0, 1'b1);
    do_read(16'h3F8, 9'h26, 64'h0, 1'b1);
    idle();
    wait_drain();
    total++; if (sb.size() !== 0) begin $display("FAIL drain_buffers: got %0d pending, required 0", sb.size()); sb.delete(); end else passed++;
  endtask

  task automatic test_rw_same_cycle();
    do_write(16'h100, 64'h40);
    idle();
    @(negedge clk);
    mmio_wr_valid = 1'b1; mmio_rd_valid = 1'b1;
    mmio_addr = 16'h100 >> 2; mmio_wr_data = 64'h80; mmio_tid = 9'h30;
    sb.push_back('{9'h30, 64'h40, cyc + 2});
    do_read(16'h100, 9'h31, 64'h80, 1'b1);
    idle();
    wait_drain();
    total++; if (sb.size() !== 0) begin $display("FAIL drain_rw: got %0d pending, required 0", sb.size()); sb.delete(); end else passed++;
  endtask

  task automatic test_done();
    @(negedge clk); afu_done = 1'b1;
    idle();
    do_read(16'h110, 9'h40, 64'h2, 1'b1);
    do_write(16'h110, 64'h2);
    afu_done = 1'b1;
    idle();
    do_read(16'h110, 9'h41, 64'h2, 1'b1);
    do_write(16'h110, 64'h2);
    idle();
    do_read(16'h110, 9'h42, 64'h0, 1'b1);
    idle();
    wait_drain();
    total++; if (sb.size() !== 0) begin $display("FAIL drain_done: got %0d pending, required 0", sb.size()); sb.delete(); end else passed++;
  endtask

  task automatic test_control();
    int n0, pulses, pulse_at;
    @(negedge clk); afu_done = 1'b1;
    idle();
    do_write(16'h108, 64'h5);
    n0 = cyc; pulses = 0; pulse_at = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) mmio_wr_valid = 1'b0;
      if (hc_start === 1'b1) begin pulses++; pulse_at = cyc; end
    end
    total++; if (pulses !== 1) $display("FAIL start_pulse_count: got %0d required 1", pulses); else passed++;
    total++; if (pulse_at !== n0 + 2) $display("FAIL start_pulse_cycle: got %0d required %0d", pulse_at, n0 + 2); else passed++;
    total++; if (hc_mode !== 30'd1) $display("FAIL mode: got %h required 1", hc_mode); else passed++;
    do_read(16'h110, 9'h50, 64'h0, 1'b1);
    do_read(16'h108, 9'h51, 64'h4, 1'b1);
    idle();
    afu_busy = 1'b1;
    idle();
    do_write(16'h108, 64'h5);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) mmio_wr_valid = 1'b0;
      if (hc_start === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) $display("FAIL start_while_busy: got %0d pulses required 0", pulses); else passed++;
    do_read(16'h110, 9'h52, 64'h5, 1'b1);
    do_write(16'h110, 64'h4);
    idle();
    do_read(16'h110, 9'h53, 64'h1, 1'b1);
    idle();
    afu_busy = 1'b0;
    wait_drain();
    total++; if (sb.size() !== 0) begin $display("FAIL drain_control: got %0d pending, required 0", sb.size()); sb.delete(); end else passed++;
  endtask

  task automatic test_busy_cycles();
    int n0, pulses, pulse_at, starts;
    bit seen;
    do_write(16'h108, 64'h1);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      mmio_wr_valid = 1'b0;
      if (hc_start === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b1) $display("FAIL busy_start_seen: got %b required 1", seen); else passed++;
    afu_busy = 1'b1;
    repeat (100) @(negedge clk);
    afu_busy = 1'b0;
    idle();
    do_read(16'h118, 9'h60, 64'd100, 1'b1);
    idle();
    afu_busy = 1'b1;
    do_write(16'h108, 64'h1);
    idle();
    afu_busy = 1'b0;
    afu_done = 1'b1;
    idle();
    do_read(16'h110, 9'h61, 64'h6, 1'b1);
    do_write(16'h108, 64'h2);
    n0 = cyc; pulses = 0; pulse_at = -1; starts = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) mmio_wr_valid = 1'b0;
      if (hc_soft_reset === 1'b1) begin pulses++; pulse_at = cyc; end
      if (hc_start === 1'b1) starts++;
    end
    total++; if (pulses !== 1) $display("FAIL soft_reset_count: got %0d required 1", pulses); else passed++;
    total++; if (pulse_at !== n0 + 2) $display("FAIL soft_reset_cycle: got %0d required %0d", pulse_at, n0 + 2); else passed++;
    total++; if (starts !== 0) $display("FAIL soft_reset_no_start: got %0d required 0", starts); else passed++;
    do_read(16'h118, 9'h62, 64'h0, 1'b1);
    do_read(16'h110, 9'h63, 64'h0, 1'b1);
    idle();
    wait_drain();
    total++; if (sb.size() !== 0) begin $display("FAIL drain_busy: got %0d pending, required 0", sb.size()); sb.delete(); end else passed++;
  endtask

  task automatic test_window();
    int seen;
    do_read(16'h400, 9'h70, 64'h0, 1'b0);
    do_read(16'hFFF8, 9'h71, 64'h0, 1'b0);
    idle();
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mmio_rd_rsp_valid === 1'b1) seen++;
    end
    total++; if (seen !== 0) $display("FAIL out_of_window: got %0d responses required 0", seen); else passed++;
  endtask

  task automatic test_reset_midflight();
    int seen;
    do_write(16'h108, 64'h100);
    idle(); idle();
    total++; if (hc_mode !== 30'h40) $display("FAIL mode_before_reset: got %h required 40", hc_mode); else passed++;
    do_read(16'h000, 9'h80, 64'h0, 1'b0);
    @(negedge clk);
    mmio_rd_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    total++; if (mmio_rd_rsp_valid !== 1'b0) $display("FAIL midreset_valid: got %b required 0", mmio_rd_rsp_valid); else passed++;
    total++; if ({hc_start, hc_soft_reset, hc_mode} !== 32'b0) $display("FAIL midreset_ctrl: got %h required 0", {hc_start, hc_soft_reset, hc_mode}); else passed++;
    total++; if ({hc_dsm_base, hc_buf_addr, hc_buf_size} !== '0) $display("FAIL midreset_regs: got nonzero, required 0"); else passed++;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mmio_rd_rsp_valid === 1'b1) seen++;
    end
    total++; if (seen !== 0) $display("FAIL midreset_rsp: got %0d responses required 0", seen); else passed++;
    do_read(16'h220, 9'h81, 64'h0, 1'b1);
    do_read(16'h108, 9'h82, 64'h0, 1'b1);
    idle();
    wait_drain();
    total++; if (sb.size() !== 0) begin $display("FAIL drain_midreset: got %0d pending, required 0", sb.size()); sb.delete(); end else passed++;
  endtask

  initial begin
    test_reset();
    test_id_regs();
    test_buffers();
    test_rw_same_cycle();
    test_done();
    test_control();
    test_busy_cycles();
    test_window();
    test_reset_midflight();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hc_csr_bank.md
Name: hc_csr_bank

Overview:
- Parametrised MMIO CSR bank for HardCloud AFUs; successor to the fixed per-sample CSR blocks.
- Serves the AFU device feature header and AFU ID, holds the DSM base and NUM_BUFFERS buffer descriptors, and issues the start/soft-reset controls.
- Adds read-back of every register, a status register with sticky done/error bits, and a busy-cycle counter.
- Sits between the FIU MMIO channel (c0 MMIO requests, c2 responses) and the AFU datapath.

Parameters:
- NUM_BUFFERS, 4, number of buffer descriptors (1..16).
- ADDR_W, 42, cache-line address width of stored addresses.
- SIZE_W, 32, width of buffer size fields.
- AFU_ID, 128'h0, 128-bit AFU UUID returned at AFU_ID_L/H.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- mmio_wr_valid  in  1  MMIO write request.
- mmio_rd_valid  in  1  MMIO read request.
- mmio_addr  in  16  DWORD address (byte offset >> 2).
- mmio_tid  in  9  read transaction ID.
- mmio_wr_data  in  64  write data.
- mmio_rd_rsp_valid  out  1  read response valid.
- mmio_rd_rsp_tid  out  9  echoed tid.
- mmio_rd_rsp_data  out  64  read data.
- afu_busy  in  1  datapath running.
- afu_done  in  1  one-cycle completion pulse.
- hc_start  out  1  one-cycle start pulse.
- hc_soft_reset  out  1  one-cycle datapath reset pulse.
- hc_mode  out  30  CONTROL[31:2].
- hc_dsm_base  out  ADDR_W  DSM cache-line address.
- hc_buf_addr  out  NUM_BUFFERS*ADDR_W  buffer i at slice i.
- hc_buf_size  out  NUM_BUFFERS*SIZE_W  buffer i at slice i.

Behaviour:
- Address map (byte offsets), all 64-bit registers at even DWORD addresses:
  - 0x000 DFH, RO, 0x1000000004000000.
  - 0x008 AFU_ID_L, RO, AFU_ID[63:0].
  - 0x010 AFU_ID_H, RO, AFU_ID[127:64].
  - 0x018 and 0x020, RO, 0.
  - 0x100 DSM_BASE, RW.
  - 0x108 CONTROL, RW.
  - 0x110 STATUS, RO with W1C bits.
  - 0x118 BUSY_CYCLES, RO.
  - 0x200+16*i BUF_ADDR[i], RW.
  - 0x208+16*i BUF_SIZE[i], RW.
- Input stage: mmio_* are registered once before decode.
- Read latency: request accepted at cycle T produces mmio_rd_rsp_valid at T+2, with tid echoed. One response per request; back-to-back reads are fully pipelined.
- Read window: byte offsets < 0x400 respond; unmapped offsets inside the window return 0. Offsets >= 0x400 produce no response. Odd DWORD addresses are treated as the enclosing 64-bit register.
- Address registers (DSM_BASE, BUF_ADDR): a write stores data[ADDR_W+5:6]; read-back returns the stored value << 6, so bits [5:0] read 0.
- BUF_SIZE write stores data[SIZE_W-1:0]; read-back is zero-extended. Writes to i >= NUM_BUFFERS are ignored and read 0.
- CONTROL write:
  - Stores data[31:2] into hc_mode.
  - data[0]=1 pulses hc_start for 1 cycle, the cycle after the registered write, provided afu_busy=0. If afu_busy=1, no pulse and STATUS.start_err is set.
  - data[1]=1 pulses hc_soft_reset and clears STATUS[2:1] and BUSY_CYCLES.
  - Bits [1:0] read back 0.
- STATUS fields:
  - bit0 live afu_busy.
  - bit1 done: sticky, set by afu_done.
  - bit2 start_err: sticky.
  - Write-1-to-clear on bits [2:1].
  - An accepted start clears done.
  - When set and clear occur in the same cycle, set wins.
- BUSY_CYCLES: 64-bit. Cleared on accepted start; increments each cycle afu_busy=1; saturates at all-ones. A clear on start takes priority over increment.
- Simultaneous read and write in one cycle: both are processed; the read returns the pre-write value.
- Reset (reset_n=0 at a clock edge): every output and register goes to 0, pending read responses are dropped, and mmio_rd_rsp_valid=0 the next cycle. Reset mid-pipeline yields no response.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Read 0x000, 0x008, 0x010, and 0x018 with tids 1-4 back-to-back -> 4 responses at T+2..T+5 with data 0x1000000004000000, AFU_ID[63:0], AFU_ID[127:64], 0, and tids in order.
- Write BUF_ADDR[2]=0x0000_1234_5678_9AC0, then read -> hc_buf_addr slice 2 = 0x48D159E26B and read-back = 0x12345678_9AC0. Write BUF_SIZE[NUM_BUFFERS] -> no change; read returns 0.
- CONTROL write 0x5 with afu_busy=0 -> single hc_start pulse, hc_mode=1, done cleared. Repeat with afu_busy=1 -> no pulse, STATUS=0x5.
- afu_done pulse, then STATUS read -> bit1=1. W1C 0x2 in the same cycle as an afu_done pulse -> bit1 stays 1.
- Start, hold afu_busy for 100 cycles -> BUSY_CYCLES=100. CONTROL write 0x2 -> hc_soft_reset pulse and BUSY_CYCLES=0.
- Read 0x400 -> no response. Assert reset_n=0 one cycle after a read request -> no response, all outputs 0.
